shared_incr_scheduler: RTL and testbench

//   Round-robin scheduler sharing one registered incrementer between NumReq requesters.

---
 rtl/shared_incr_scheduler_if.sv | 49 ++++
 rtl/shared_incr_scheduler.sv | 127 ++++++++++++
 tb/tb_shared_incr_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/shared_incr_scheduler_if.sv
// Bundles the request and result handshake of shared_incr_scheduler.
//
// Request side (one lane per requester):
//   req_valid  NumReq             bit i: requester i presents an operand
//   req_data   NumReq*DataWidth   requester i operand in bits [i*DataWidth +: DataWidth]
//   req_ready  NumReq             bit i: requester i's operand is accepted this cycle
// Result side:
//   res_valid  1                  result slot holds a result
//   res_data   DataWidth          registered operand + 1
//   res_id     IdWidth            index of the requester that produced res_data
//   res_ready  1                  consumer accepts the result this cycle
//
// Modports:
//   slave   the scheduler (consumes requests, produces results)
//   master  the client/consumer environment around it
interface shared_incr_scheduler_if #(
  parameter int DataWidth = 16,
  parameter int NumReq    = 4
);
  localparam int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]           req_valid;
  logic [NumReq*DataWidth-1:0] req_data;
  logic [NumReq-1:0]           req_ready;
  logic                        res_valid;
  logic [DataWidth-1:0]        res_data;
  logic [IdWidth-1:0]          res_id;
  logic                        res_ready;

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output res_valid,
    output res_data,
    output res_id,
    input  res_ready
  );

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  res_valid,
    input  res_data,
    input  res_id,
    output res_ready
  );
endinterface

// File: rtl/shared_incr_scheduler.sv
// Round-robin scheduler sharing a single registered incrementer between
// NumReq requesters. Each cycle at most one requester is granted; its operand
// plus one is captured in a one-entry result slot together with the winner's
// index and offered on a valid/ready result port.
//
// Ports:
//   clk   in   clock, all state updates on posedge
//   rst   in   synchronous reset, active-high
//   bus   slave modport of shared_incr_scheduler_if (request lanes in,
//         req_ready out, registered result port out, res_ready in)
//
// The result port is driven straight from flops, so there is no
// combinational path from any req_* input to any res_* output. req_ready
// does depend combinationally on req_valid and res_ready.
module shared_incr_scheduler #(
  parameter int DataWidth = 16,
  parameter int NumReq    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  shared_incr_scheduler_if.slave bus
);

  localparam int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  // Result slot and round-robin pointer.
  logic                 res_valid_q, res_valid_d;
  logic [DataWidth-1:0] res_data_q,  res_data_d;
  logic [IdWidth-1:0]   res_id_q,    res_id_d;
  logic [IdWidth-1:0]   ptr_q,       ptr_d;

  // Arbitration results.
  logic                 can_accept;
  logic                 any_valid;
  logic                 grant;
  logic [IdWidth-1:0]   win_id;
  logic [IdWidth-1:0]   cand_id;
  int                   cand_sum;
  logic [DataWidth-1:0] operand [NumReq];
  logic [DataWidth-1:0] win_operand;
  logic [NumReq-1:0]    req_ready;

  // Split the flat operand bus into per-requester lanes.
  always_comb begin : split_lanes
    for (int i = 0; i < NumReq; i++) begin
      operand[i] = bus.req_data[i*DataWidth +: DataWidth];
    end
  end

  // Slot can take a new operand when it is empty or being drained this cycle.
  assign can_accept = !res_valid_q || bus.res_ready;

  // Search ptr, ptr+1, ... (mod NumReq); the first valid requester wins.
  // The wrap is a compare-and-subtract because ptr+k never reaches 2*NumReq.
  always_comb begin : arbitrate
    any_valid = 1'b0;
    win_id    = '0;
    cand_sum  = 0;
    cand_id   = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand_sum = int'(ptr_q) + k;
      if (cand_sum >= NumReq) begin
        cand_sum = cand_sum - NumReq;
      end
      cand_id = IdWidth'(cand_sum);
      if (!any_valid && bus.req_valid[cand_id]) begin
        any_valid = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  assign win_operand = operand[win_id];

  // rst gates grants so nothing is accepted while the slot is being cleared.
  assign grant = !rst && can_accept && any_valid;

  always_comb begin : ready_decode
    req_ready = '0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign bus.req_ready = req_ready;

  always_comb begin : next_state
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    ptr_d       = ptr_q;
    if (grant) begin
      // A grant also covers the drain-and-refill case: the old result
      // leaves and the new one lands in the same edge, with no bubble.
      res_valid_d = 1'b1;
      res_data_d  = win_operand + DataWidth'(1);
      res_id_d    = win_id;
      if (int'(win_id) == NumReq - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_id + IdWidth'(1);
      end
    end else if (bus.res_ready) begin
      // Drained with nothing to refill; data and id keep their last value.
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin : state_regs
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_shared_incr_scheduler.sv
module tb_shared_incr_scheduler;

  localparam int DW = 16;
  localparam int NR = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst;

  shared_incr_scheduler_if #(.DataWidth(DW), .NumReq(NR)) bus ();

  shared_incr_scheduler #(.DataWidth(DW), .NumReq(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk;
  int   n_pass;
  exp_t sb_q[$];
  int   m_ptr;
  int   last_win;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge against the
  // reference model, then advance the model across the rising edge.
  task automatic step(input logic r, input logic [3:0] v, input logic [63:0] d,
                      input logic rr);
    logic [3:0] exp_ready;
    int         win;
    int         idx;
    logic       acc;
    exp_t       e;
    rst           = r;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.res_ready = rr;
    @(negedge clk);
    exp_ready = '0;
    win       = -1;
    acc       = (sb_q.size() == 0) || rr;
    if (!r && acc) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("res_valid", 32'(bus.res_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      chk("res_id", 32'(bus.res_id), 32'(sb_q[0].id));
      chk("res_data", 32'(bus.res_data), 32'(sb_q[0].data));
    end
    @(posedge clk);
    last_win = win;
    if (r) begin
      sb_q.delete();
      m_ptr = 0;
    end else begin
      if (sb_q.size() != 0 && rr) void'(sb_q.pop_front());
      if (win >= 0) begin
        e.id   = 2'(win);
        e.data = d[win*16 +: 16] + 16'd1;
        sb_q.push_back(e);
        m_ptr = (win + 1) % NR;
      end
    end
    #1;
  endtask

  logic [63:0] lanes;
  int          rr_order [5];
  int          held_id;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    m_ptr  = 0;
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held for two cycles with every requester valid.
    step(1'b1, 4'b1111, 64'h0, 1'b0);
    step(1'b1, 4'b1111, 64'h0, 1'b0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);

    // Single request from id 2.
    lanes = 64'h1111_0041_2222_3333;
    step(1'b0, 4'b0100, lanes, 1'b1);
    chk("single_win", 32'(last_win), 32'd2);
    chk("single_data", 32'(bus.res_data), 32'h0042);
    chk("single_id", 32'(bus.res_id), 32'd2);
    step(1'b0, 4'b0000, lanes, 1'b1);

    // Round robin from a fresh pointer: expect 0,1,2,3,0 back to back.
    step(1'b1, 4'b0000, 64'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      lanes = {$urandom, $urandom};
      step(1'b0, 4'b1111, lanes, 1'b1);
      rr_order[c] = int'(bus.res_id);
      chk("rr_valid", 32'(bus.res_valid), 32'd1);
    end
    chk("rr_id0", 32'(rr_order[0]), 32'd0);
    chk("rr_id1", 32'(rr_order[1]), 32'd1);
    chk("rr_id2", 32'(rr_order[2]), 32'd2);
    chk("rr_id3", 32'(rr_order[3]), 32'd3);
    chk("rr_id4", 32'(rr_order[4]), 32'd0);

    // Backpressure: slot stays full for five cycles, then same-cycle refill.
    held_id = int'(bus.res_id);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 4'b1111, {$urandom, $urandom}, 1'b0);
      chk("bp_hold_id", 32'(bus.res_id), 32'(held_id));
    end
    step(1'b0, 4'b1111, {$urandom, $urandom}, 1'b1);
    chk("bp_refill_valid", 32'(bus.res_valid), 32'd1);
    chk("bp_next_id", 32'(bus.res_id), 32'((held_id + 1) % NR));
    step(1'b0, 4'b0000, 64'h0, 1'b1);
    step(1'b0, 4'b0000, 64'h0, 1'b1);

    // Operand wrap: all-ones plus one becomes zero.
    lanes = 64'h0000_0000_0000_FFFF;
    step(1'b0, 4'b0001, lanes, 1'b1);
    chk("wrap_data", 32'(bus.res_data), 32'h0000);
    chk("wrap_id", 32'(bus.res_id), 32'd0);
    step(1'b0, 4'b0000, lanes, 1'b1);

    // Reset while the slot is full with id 1.
    step(1'b1, 4'b0000, 64'h0, 1'b0);
    lanes = 64'h0000_0000_1234_0000;
    step(1'b0, 4'b0010, lanes, 1'b0);
    chk("mid_full_id", 32'(bus.res_id), 32'd1);
    step(1'b1, 4'b1111, {$urandom, $urandom}, 1'b0);
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.res_data), 32'd0);
    step(1'b0, 4'b1111, {$urandom, $urandom}, 1'b1);
    chk("mid_next_id", 32'(bus.res_id), 32'd0);
    step(1'b0, 4'b0000, 64'h0, 1'b1);
    step(1'b0, 4'b0000, 64'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
